// File: rtl/phy_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : phy_cmd_seq
//  Description : DDR3 command sequencer in the clk_div domain. It accepts one
//                command word per valid/ready handshake, presents it to
//                phy_top for one ISSUE cycle, then inserts a programmable
//                number of NOP cycles before the next command can issue.
//  Revision    : 1.0  initial release
// ============================================================================
module phy_cmd_seq #(
    parameter int ADDRESS_NUMBER = 15,
    parameter int PAUSE_WIDTH    = 10
) (
    input  logic                        clk_div,
    input  logic                        rst,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDRESS_NUMBER-1:0]   cmd_a,
    input  logic [2:0]                  cmd_ba,
    input  logic [2:0]                  cmd_rcw,
    input  logic                        cmd_cke,
    input  logic                        cmd_odt,
    input  logic                        cmd_tri,
    input  logic                        cmd_dq_en,
    input  logic                        cmd_dqs_en,
    input  logic [PAUSE_WIDTH-1:0]      cmd_pause,

    output logic [2*ADDRESS_NUMBER-1:0] in_a,
    output logic [5:0]                  in_ba,
    output logic [1:0]                  in_ras,
    output logic [1:0]                  in_cas,
    output logic [1:0]                  in_we,
    output logic [1:0]                  in_cke,
    output logic [1:0]                  in_odt,
    output logic                        in_tri,
    output logic [7:0]                  tin_dq,
    output logic [7:0]                  tin_dqs,
    output logic [7:0]                  din_dqs,

    output logic                        busy,
    output logic                        issued
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                 state;
    logic [PAUSE_WIDTH-1:0] pause_cnt;
    logic                   accept;

    // Ready when idle, or when the current command's NOP gap ends this cycle,
    // so that the next command issues immediately after the last NOP.
    always_comb begin
        cmd_ready = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE:  cmd_ready = 1'b1;
                ST_ISSUE: cmd_ready = (pause_cnt == '0);
                ST_PAUSE: cmd_ready = (pause_cnt == PAUSE_WIDTH'(1));
                default:  cmd_ready = 1'b0;
            endcase
        end
    end

    assign accept = cmd_valid && cmd_ready;

    // Sequencer FSM: ISSUE for one cycle, then count down the NOP gap in PAUSE.
    // The count is not decremented on the ISSUE->PAUSE transition, so a gap of
    // N yields exactly N PAUSE cycles (N, N-1, ..., 1).
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state     <= ST_IDLE;
            pause_cnt <= '0;
            busy      <= 1'b0;
            issued    <= 1'b0;
        end else begin
            issued <= accept;
            if (accept) begin
                state     <= ST_ISSUE;
                pause_cnt <= cmd_pause;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    ST_ISSUE: begin
                        if (pause_cnt == '0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        pause_cnt <= pause_cnt - PAUSE_WIDTH'(1);
                        if (pause_cnt == PAUSE_WIDTH'(1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        pause_cnt <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // PHY-facing registers: command pins pulse for one cycle, address/bank and
    // the sticky controls only change when a command is issued.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            in_a    <= '0;
            in_ba   <= '0;
            in_ras  <= 2'b11;
            in_cas  <= 2'b11;
            in_we   <= 2'b11;
            in_cke  <= 2'b00;
            in_odt  <= 2'b00;
            in_tri  <= 1'b1;
            tin_dq  <= 8'hFF;
            tin_dqs <= 8'hFF;
            din_dqs <= 8'h00;
        end else begin
            in_ras <= 2'b11;
            in_cas <= 2'b11;
            in_we  <= 2'b11;
            if (accept) begin
                // Command asserted in the first half-cycle, NOP in the second.
                in_ras  <= {cmd_rcw[2], 1'b1};
                in_cas  <= {cmd_rcw[1], 1'b1};
                in_we   <= {cmd_rcw[0], 1'b1};
                in_a    <= {cmd_a, cmd_a};
                in_ba   <= {cmd_ba, cmd_ba};
                in_cke  <= {2{cmd_cke}};
                in_odt  <= {2{cmd_odt}};
                in_tri  <= cmd_tri;
                tin_dq  <= {8{~cmd_dq_en}};
                tin_dqs <= {8{~cmd_dqs_en}};
                din_dqs <= cmd_dqs_en ? 8'h55 : 8'h00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_cmd_seq
//  Description : Self-checking bench for phy_cmd_seq. A cycle-numbered model
//                predicts ready/busy and the PHY pins; a directed table plus
//                hand-written sequences and a randomized phase drive the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_phy_cmd_seq;

    localparam int AN = 15;
    localparam int PW = 10;

    logic            clk_div = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AN-1:0]   cmd_a;
    logic [2:0]      cmd_ba;
    logic [2:0]      cmd_rcw;
    logic            cmd_cke, cmd_odt, cmd_tri, cmd_dq_en, cmd_dqs_en;
    logic [PW-1:0]   cmd_pause;
    logic [2*AN-1:0] in_a;
    logic [5:0]      in_ba;
    logic [1:0]      in_ras, in_cas, in_we, in_cke, in_odt;
    logic            in_tri;
    logic [7:0]      tin_dq, tin_dqs, din_dqs;
    logic            busy, issued;

    always #5 clk_div = ~clk_div;

    phy_cmd_seq #(.ADDRESS_NUMBER(AN), .PAUSE_WIDTH(PW)) dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_ba     (cmd_ba),
        .cmd_rcw    (cmd_rcw),
        .cmd_cke    (cmd_cke),
        .cmd_odt    (cmd_odt),
        .cmd_tri    (cmd_tri),
        .cmd_dq_en  (cmd_dq_en),
        .cmd_dqs_en (cmd_dqs_en),
        .cmd_pause  (cmd_pause),
        .in_a       (in_a),
        .in_ba      (in_ba),
        .in_ras     (in_ras),
        .in_cas     (in_cas),
        .in_we      (in_we),
        .in_cke     (in_cke),
        .in_odt     (in_odt),
        .in_tri     (in_tri),
        .tin_dq     (tin_dq),
        .tin_dqs    (tin_dqs),
        .din_dqs    (din_dqs),
        .busy       (busy),
        .issued     (issued)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: absolute cycle numbers. A command issued at cycle c with pause P
    // keeps the block busy through c+P and allows the next acceptance from c+P.
    longint          cyc;
    longint          ready_at;
    longint          busy_until;
    logic [2*AN-1:0] e_a;
    logic [5:0]      e_ba;
    logic [1:0]      e_ras, e_cas, e_we, e_cke, e_odt;
    logic            e_tri, e_issued;
    logic [7:0]      e_tin_dq, e_tin_dqs, e_din_dqs;
    logic            last_acc;
    logic            obs_issued, obs_ready, obs_busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset_values();
        e_a = '0; e_ba = '0;
        e_ras = 2'b11; e_cas = 2'b11; e_we = 2'b11;
        e_cke = 2'b00; e_odt = 2'b00; e_tri = 1'b1;
        e_tin_dq = 8'hFF; e_tin_dqs = 8'hFF; e_din_dqs = 8'h00;
        e_issued = 1'b0;
        busy_until = -1;
    endtask

    task automatic set_cmd(input logic v, input logic [2:0] rcw, input logic [AN-1:0] a,
                           input logic [2:0] ba, input logic cke, input logic odt,
                           input logic tr, input logic dq, input logic dqs,
                           input logic [PW-1:0] p);
        cmd_valid = v; cmd_rcw = rcw; cmd_a = a; cmd_ba = ba;
        cmd_cke = cke; cmd_odt = odt; cmd_tri = tr;
        cmd_dq_en = dq; cmd_dqs_en = dqs; cmd_pause = p;
    endtask

    // Called just after a falling edge with inputs already applied: check the
    // DUT against the model, advance the model, move to the next falling edge.
    task automatic step();
        logic e_ready, e_busy, acc;
        #1;
        e_ready    = !rst && (cyc >= ready_at);
        e_busy     = (cyc <= busy_until);
        obs_issued = issued;
        obs_ready  = cmd_ready;
        obs_busy   = busy;
        chk("cmd_ready", cmd_ready, e_ready);
        chk("busy",      busy,      e_busy);
        chk("issued",    issued,    e_issued);
        chk("in_a",      in_a,      e_a);
        chk("in_ba",     in_ba,     e_ba);
        chk("in_ras",    in_ras,    e_ras);
        chk("in_cas",    in_cas,    e_cas);
        chk("in_we",     in_we,     e_we);
        chk("in_cke",    in_cke,    e_cke);
        chk("in_odt",    in_odt,    e_odt);
        chk("in_tri",    in_tri,    e_tri);
        chk("tin_dq",    tin_dq,    e_tin_dq);
        chk("tin_dqs",   tin_dqs,   e_tin_dqs);
        chk("din_dqs",   din_dqs,   e_din_dqs);
        acc = cmd_valid && e_ready;
        if (rst) begin
            model_reset_values();
            ready_at = cyc + 1;
        end else begin
            e_ras = 2'b11; e_cas = 2'b11; e_we = 2'b11;
            e_issued = 1'b0;
            if (acc) begin
                e_ras     = {cmd_rcw[2], 1'b1};
                e_cas     = {cmd_rcw[1], 1'b1};
                e_we      = {cmd_rcw[0], 1'b1};
                e_a       = {cmd_a, cmd_a};
                e_ba      = {cmd_ba, cmd_ba};
                e_cke     = {2{cmd_cke}};
                e_odt     = {2{cmd_odt}};
                e_tri     = cmd_tri;
                e_tin_dq  = {8{~cmd_dq_en}};
                e_tin_dqs = {8{~cmd_dqs_en}};
                e_din_dqs = cmd_dqs_en ? 8'h55 : 8'h00;
                e_issued  = 1'b1;
                ready_at   = cyc + 1 + longint'(cmd_pause);
                busy_until = cyc + 1 + longint'(cmd_pause);
            end
        end
        last_acc = acc;
        @(negedge clk_div);
        cyc++;
    endtask

    // Steps with the current inputs until a second issue pulse is seen,
    // measuring the NOP gap and the ready value on the last three NOP cycles.
    task automatic gap_run(input int budget, output int gap, output int issues,
                           output logic [2:0] tail_ready);
        gap = 0; issues = 0; tail_ready = 3'b000;
        for (int k = 0; k < budget; k++) begin
            step();
            if (obs_issued) begin
                issues++;
                if (issues == 2) break;
            end else if (issues == 1) begin
                gap++;
                tail_ready = {tail_ready[1:0], obs_ready};
            end
        end
    endtask

    typedef struct {
        logic            v;
        logic [2:0]      rcw;
        logic [AN-1:0]   a;
        logic [2:0]      ba;
        logic            cke, dq, dqs;
        logic [PW-1:0]   p;
        logic            x_ready, x_issued, x_busy;
        logic [1:0]      x_ras, x_cas, x_we, x_cke;
        logic [2*AN-1:0] x_a;
        logic [5:0]      x_ba;
        logic [7:0]      x_tin_dq, x_din_dqs;
    } vec_t;

    vec_t tbl [0:8];

    initial begin
        int gap, issues, cnt;
        logic [2:0] tail;
        logic [7:0] hist;
        logic hold;

        // Directed sequence: ACT, idle, WR, NOP-command with pause 2, and a
        // held command that waits out the pause. Expected values are the
        // outputs visible during the cycle the inputs are applied.
        tbl[0] = '{1'b1, 3'b011, 15'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 10'd0,
                   1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 30'h0, 6'h00, 8'hFF, 8'h00};
        tbl[1] = '{1'b0, 3'b000, 15'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 10'd0,
                   1'b1, 1'b1, 1'b1, 2'b01, 2'b11, 2'b11, 2'b11, {15'h1234, 15'h1234}, 6'b011011, 8'hFF, 8'h00};
        tbl[2] = '{1'b1, 3'b100, 15'h00AA, 3'd1, 1'b1, 1'b1, 1'b1, 10'd0,
                   1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11, {15'h1234, 15'h1234}, 6'b011011, 8'hFF, 8'h00};
        tbl[3] = '{1'b1, 3'b111, 15'h7FFF, 3'd7, 1'b1, 1'b0, 1'b0, 10'd2,
                   1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 2'b01, 2'b11, {15'h00AA, 15'h00AA}, 6'b001001, 8'h00, 8'h55};
        tbl[4] = '{1'b1, 3'b101, 15'h0001, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0,
                   1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, {15'h7FFF, 15'h7FFF}, 6'h3F, 8'hFF, 8'h00};
        tbl[5] = '{1'b1, 3'b101, 15'h0001, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0,
                   1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, {15'h7FFF, 15'h7FFF}, 6'h3F, 8'hFF, 8'h00};
        tbl[6] = '{1'b1, 3'b101, 15'h0001, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0,
                   1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, {15'h7FFF, 15'h7FFF}, 6'h3F, 8'hFF, 8'h00};
        tbl[7] = '{1'b0, 3'b101, 15'h0001, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0,
                   1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 2'b11, 2'b00, {15'h0001, 15'h0001}, 6'b010010, 8'hFF, 8'h00};
        tbl[8] = '{1'b0, 3'b101, 15'h0001, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0,
                   1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, {15'h0001, 15'h0001}, 6'b010010, 8'hFF, 8'h00};

        // Reset held for three cycles; the first is unchecked (DUT state unknown).
        rst = 1'b1;
        set_cmd(1'b0, 3'b111, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc = 0;
        last_acc = 1'b0;
        @(negedge clk_div);
        @(negedge clk_div);
        model_reset_values();
        ready_at = 0;
        step();
        step();
        rst = 1'b0;

        // Directed table, starting on the first cycle after reset release.
        for (int i = 0; i < 9; i++) begin
            set_cmd(tbl[i].v, tbl[i].rcw, tbl[i].a, tbl[i].ba, tbl[i].cke, 1'b0, 1'b0,
                    tbl[i].dq, tbl[i].dqs, tbl[i].p);
            #1;
            chk("tbl_ready",   cmd_ready, tbl[i].x_ready);
            chk("tbl_issued",  issued,    tbl[i].x_issued);
            chk("tbl_busy",    busy,      tbl[i].x_busy);
            chk("tbl_ras",     in_ras,    tbl[i].x_ras);
            chk("tbl_cas",     in_cas,    tbl[i].x_cas);
            chk("tbl_we",      in_we,     tbl[i].x_we);
            chk("tbl_cke",     in_cke,    tbl[i].x_cke);
            chk("tbl_a",       in_a,      tbl[i].x_a);
            chk("tbl_ba",      in_ba,     tbl[i].x_ba);
            chk("tbl_tin_dq",  tin_dq,    tbl[i].x_tin_dq);
            chk("tbl_din_dqs", din_dqs,   tbl[i].x_din_dqs);
            step();
        end

        // Pause of 3 with the follow-up command held valid.
        set_cmd(1'b1, 3'b011, 15'h0055, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd3);
        step();
        set_cmd(1'b1, 3'b101, 15'h0066, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        gap_run(12, gap, issues, tail);
        chk("pause3_issues", issues, 2);
        chk("pause3_gap", gap, 3);
        chk("pause3_ready_pattern", tail, 3'b001);
        cmd_valid = 1'b0;
        step();
        step();

        // Four back-to-back commands with no pause.
        hist = '0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 3'(i), AN'(i + 16), 3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
            step();
            hist = {hist[6:0], obs_issued};
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            hist = {hist[6:0], obs_issued};
        end
        chk("b2b_issue_pattern", hist, 8'b01111000);

        // Maximum pause must not wrap.
        set_cmd(1'b1, 3'b010, 15'h4321, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF);
        step();
        set_cmd(1'b1, 3'b110, 15'h1111, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        gap_run(1100, gap, issues, tail);
        chk("maxpause_issues", issues, 2);
        chk("maxpause_gap", gap, 1023);
        cmd_valid = 1'b0;
        step();
        step();

        // Reset on the 4th NOP cycle of a pause-10 command aborts it.
        set_cmd(1'b1, 3'b011, 15'h0F0F, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'd10);
        step();
        cmd_valid = 1'b0;
        step();
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_mid_busy", obs_busy, 1'b0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            cnt += int'(obs_issued);
        end
        chk("rst_mid_no_issue", cnt, 0);

        // Randomized traffic; a refused command is held by the source.
        hold = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst = ($urandom_range(0, 99) == 0);
            if (!hold) begin
                r = $urandom_range(0, 19);
                set_cmd(($urandom_range(0, 2) != 0), 3'($urandom), AN'($urandom), 3'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        (r < 10) ? 10'd0 :
                        (r < 17) ? 10'($urandom_range(1, 4)) :
                        (r < 19) ? 10'($urandom_range(5, 20)) :
                                   10'($urandom_range(100, 1023)));
            end
            step();
            hold = cmd_valid && !last_acc && !rst;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phy_cmd_seq.md
PHY_CMD_SEQ -- requirements
Module: phy_cmd_seq

Interface
REQ-001 SHALL have parameter ADDRESS_NUMBER, default 15, DDR3 address width.
REQ-002 SHALL have parameter PAUSE_WIDTH, default 10, width of the per-command NOP pause count.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_div  input  1  the only clock, the same clk_div that drives phy_top.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command word present.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_a  input  ADDRESS_NUMBER  address.
REQ-009 SHALL have port cmd_ba  input  3  bank address.
REQ-010 SHALL have port cmd_rcw  input  3  {ras_n, cas_n, we_n}.
REQ-011 SHALL have port cmd_cke, cmd_odt, cmd_tri, cmd_dq_en, cmd_dqs_en  input  1 each  sticky controls.
REQ-012 SHALL have port cmd_pause  input  PAUSE_WIDTH  NOP cycles after the command.
REQ-013 SHALL have ports in_a  output  2*ADDRESS_NUMBER; in_ba  output  6; in_ras, in_cas, in_we, in_cke, in_odt  output  2 each; in_tri  output  1. These drive phy_top directly.
REQ-014 SHALL have ports tin_dq, tin_dqs, din_dqs  output  8 each, to phy_top.
REQ-015 SHALL have port busy  output  1  state != IDLE.
REQ-016 SHALL have port issued  output  1  one-cycle pulse, coincident with the ISSUE cycle.

Function
REQ-017 Each 2-bit phy field SHALL carry the first half-cycle in bit[1] and the second in bit[0]; in_a and in_ba SHALL carry the first half in the upper half of the field.
REQ-018 All phy outputs SHALL be registered on clk_div.
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and PAUSE.
REQ-020 cmd_ready SHALL be !rst and (IDLE, or ISSUE with pause_cnt==0, or PAUSE with pause_cnt==1).
REQ-021 On acceptance at cycle t, the state at t+1 SHALL be ISSUE and pause_cnt SHALL be loaded with cmd_pause.
REQ-022 In the ISSUE cycle the outputs SHALL be:
- in_ras={ras_n,1}, in_cas={cas_n,1}, in_we={we_n,1};
- in_a={cmd_a,cmd_a}, in_ba={cmd_ba,cmd_ba};
- issued=1.
REQ-023 Outside ISSUE, in_ras, in_cas and in_we SHALL be 2'b11 (NOP), and in_a and in_ba SHALL hold their last values.
REQ-024 The sticky controls SHALL update only on the ISSUE cycle and hold until the next ISSUE:
- in_cke={2{cke}}, in_odt={2{odt}}, in_tri=tri;
- tin_dq={8{~dq_en}}, tin_dqs={8{~dqs_en}};
- din_dqs = dqs_en ? 8'h55 : 8'h00.
REQ-025 From ISSUE, the next state SHALL be:
- ISSUE if pause_cnt==0 and a new command is accepted;
- IDLE if pause_cnt==0 and no command is accepted;
- PAUSE otherwise.
REQ-026 In PAUSE, pause_cnt SHALL decrement each cycle.
REQ-027 When pause_cnt==1 in PAUSE, the next state SHALL be ISSUE if a command is accepted, else IDLE.
REQ-028 Exactly cmd_pause NOP cycles SHALL separate consecutive ISSUE cycles under back-to-back cmd_valid.
REQ-029 cmd_pause at its maximum value (all ones) SHALL be honoured without wrap.
REQ-030 When cmd_valid is high and cmd_ready is low, the command SHALL be ignored, and the source SHALL hold it.

Reset
REQ-031 While rst is high, every clock SHALL force:
- state IDLE, pause_cnt=0, cmd_ready=0, busy=0, issued=0;
- in_a=0, in_ba=0, in_ras=in_cas=in_we=2'b11;
- in_cke=2'b00, in_odt=2'b00, in_tri=1;
- tin_dq=tin_dqs=8'hFF, din_dqs=8'h00.
REQ-032 Reset asserted mid-ISSUE or mid-PAUSE SHALL abort the command, with no further ISSUE from the aborted command.
REQ-033 The first acceptance after reset SHALL be possible on the first cycle after rst deasserts.

Verification
REQ-034 Reset check: hold rst for 3 cycles, then release -> all outputs at their REQ-031 values, and cmd_ready=1 on the first cycle after release.
REQ-035 Single command with pause=0: ACT (rcw=3'b011, a=15'h1234, ba=3, cke=1) accepted at t -> at t+1 in_ras=2'b01, in_cas=2'b11, in_we=2'b11, in_a={2{15'h1234}}, in_ba=6'b011011, in_cke=2'b11, issued=1; at t+2 IDLE and NOP.
REQ-036 Pause timing: command with pause=3, then a second command with cmd_valid held high -> ISSUE, 3 NOP cycles, ISSUE; cmd_ready high only on the third NOP cycle.
REQ-037 Back-to-back with pause=0: 4 commands streamed -> 4 consecutive ISSUE cycles with no NOP between them.
REQ-038 Write path: WR (rcw=3'b100) with dq_en=1, dqs_en=1, then a NOP command (rcw=3'b111, dq_en=0, dqs_en=0) -> tin_dq=8'h00, tin_dqs=8'h00, din_dqs=8'h55 from the WR ISSUE cycle; back to FF/FF/00 on the NOP command's ISSUE cycle.
REQ-039 Reset mid-pause: command with pause=10, rst asserted on the 4th NOP cycle -> reset values on the next cycle and no further issued pulse.
